// File: rtl/wb_commit_regfile.sv
// Writeback-stage commit block for a dual-issue pipeline.
// Commits both slots to a 32x32 GPR file and slot 0 to HI/LO. Serves four
// bypassed read ports to decode. Serialises commits into a one-per-cycle
// debug trace through a small FIFO.
module wb_commit_regfile #(
    parameter int unsigned TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wen0_i,
    input  logic [4:0]  waddr0_i,
    input  logic [1:0]  ls0_i,
    input  logic [31:0] memout0_i,
    input  logic [31:0] aluout0_i,
    input  logic [31:0] pc0_i,
    input  logic        wen1_i,
    input  logic [4:0]  waddr1_i,
    input  logic [31:0] aluout1_i,
    input  logic [31:0] pc1_i,
    input  logic [1:0]  hilo_we_i,
    input  logic [63:0] hilo_wdata_i,
    input  logic [4:0]  raddr0_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    input  logic [4:0]  raddr3_i,
    output logic [31:0] rdata0_o,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    output logic [31:0] rdata3_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic        trace_afull_o,
    output logic        trace_ovf_o
);

    localparam int unsigned PW = $clog2(TRACE_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0] gpr [32];
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        wr0;
    logic        wr1;

    assign wdata0 = (ls0_i == 2'b01) ? memout0_i : aluout0_i;
    assign wdata1 = aluout1_i;
    assign wr0    = wen0_i && (waddr0_i != 5'd0);
    assign wr1    = wen1_i && (waddr1_i != 5'd0);

    // GPR commit; slot 1 is written last so it wins on an address collision
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            if (wr0) gpr[waddr0_i] <= wdata0;
            if (wr1) gpr[waddr1_i] <= wdata1;
        end
    end

    logic [4:0]  raddr [4];
    logic [31:0] rdata [4];

    assign raddr[0] = raddr0_i;
    assign raddr[1] = raddr1_i;
    assign raddr[2] = raddr2_i;
    assign raddr[3] = raddr3_i;

    // Read ports with same-cycle bypass, slot 1 taking priority over slot 0
    always_comb begin
        for (int unsigned p = 0; p < 4; p++) begin
            rdata[p] = '0;
            if (raddr[p] != 5'd0) begin
                if (wen1_i && (waddr1_i == raddr[p]))
                    rdata[p] = wdata1;
                else if (wen0_i && (waddr0_i == raddr[p]))
                    rdata[p] = wdata0;
                else
                    rdata[p] = gpr[raddr[p]];
            end
        end
    end

    assign rdata0_o = rdata[0];
    assign rdata1_o = rdata[1];
    assign rdata2_o = rdata[2];
    assign rdata3_o = rdata[3];

    // HI/LO commit, each half enabled independently
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hilo_we_i[1]) hi_q <= hilo_wdata_i[63:32];
            if (hilo_we_i[0]) lo_q <= hilo_wdata_i[31:0];
        end
    end

    assign hi_o = hilo_we_i[1] ? hilo_wdata_i[63:32] : hi_q;
    assign lo_o = hilo_we_i[0] ? hilo_wdata_i[31:0]  : lo_q;

    // Trace FIFO
    logic [31:0]   fifo_pc   [TRACE_DEPTH];
    logic [4:0]    fifo_num  [TRACE_DEPTH];
    logic [31:0]   fifo_data [TRACE_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr1;
    logic [CW-1:0] count;
    logic [CW-1:0] avail;
    logic [CW-1:0] count_next;
    logic          pop;
    logic          acc0;
    logic          acc1;
    logic          drop;

    // Free slots this edge include the one vacated by the pop; slot 0 claims
    // first so an overflow always drops slot 1 before slot 0.
    always_comb begin
        pop        = (count != '0);
        avail      = CW'(TRACE_DEPTH) - count + CW'(pop);
        acc0       = wen0_i && (avail != '0);
        acc1       = wen1_i && (avail > CW'(acc0));
        drop       = (wen0_i && !acc0) || (wen1_i && !acc1);
        wr_ptr1    = wr_ptr + PW'(acc0);
        count_next = count + CW'(acc0) + CW'(acc1) - CW'(pop);
    end

    assign trace_afull_o = (count >= CW'(TRACE_DEPTH - 1));

    // Trace storage writes; contents are only read while count is non-zero
    always_ff @(posedge clk) begin
        if (acc0) begin
            fifo_pc[wr_ptr]   <= pc0_i;
            fifo_num[wr_ptr]  <= waddr0_i;
            fifo_data[wr_ptr] <= wdata0;
        end
        if (acc1) begin
            fifo_pc[wr_ptr1]   <= pc1_i;
            fifo_num[wr_ptr1]  <= waddr1_i;
            fifo_data[wr_ptr1] <= wdata1;
        end
    end

    // Trace pointers, occupancy, overflow flag and registered debug outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            trace_ovf_o       <= 1'b0;
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(acc0) + PW'(acc1);
            count  <= count_next;
            if (drop) trace_ovf_o <= 1'b1;
            if (pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                debug_wb_pc       <= fifo_pc[rd_ptr];
                debug_wb_rf_wnum  <= fifo_num[rd_ptr];
                debug_wb_rf_wdata <= fifo_data[rd_ptr];
                debug_wb_rf_wen   <= (fifo_num[rd_ptr] != 5'd0) ? 4'hf : 4'h0;
            end else begin
                debug_wb_rf_wen   <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_regfile.sv
// Directed bench for wb_commit_regfile: direct checks on the register file
// and HI/LO, plus a trace scoreboard drained by an independent monitor.
module tb_wb_commit_regfile;

    logic        clk;
    logic        resetn;
    logic        wen0_i;
    logic [4:0]  waddr0_i;
    logic [1:0]  ls0_i;
    logic [31:0] memout0_i;
    logic [31:0] aluout0_i;
    logic [31:0] pc0_i;
    logic        wen1_i;
    logic [4:0]  waddr1_i;
    logic [31:0] aluout1_i;
    logic [31:0] pc1_i;
    logic [1:0]  hilo_we_i;
    logic [63:0] hilo_wdata_i;
    logic [4:0]  raddr0_i, raddr1_i, raddr2_i, raddr3_i;
    logic [31:0] rdata0_o, rdata1_o, rdata2_o, rdata3_o;
    logic [31:0] hi_o, lo_o;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        trace_afull_o;
    logic        trace_ovf_o;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [3:0]  wen;
    } tr_t;

    tr_t sb [$];
    int  tests = 0;
    int  fails = 0;

    wb_commit_regfile #(.TRACE_DEPTH(4)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .wen0_i            (wen0_i),
        .waddr0_i          (waddr0_i),
        .ls0_i             (ls0_i),
        .memout0_i         (memout0_i),
        .aluout0_i         (aluout0_i),
        .pc0_i             (pc0_i),
        .wen1_i            (wen1_i),
        .waddr1_i          (waddr1_i),
        .aluout1_i         (aluout1_i),
        .pc1_i             (pc1_i),
        .hilo_we_i         (hilo_we_i),
        .hilo_wdata_i      (hilo_wdata_i),
        .raddr0_i          (raddr0_i),
        .raddr1_i          (raddr1_i),
        .raddr2_i          (raddr2_i),
        .raddr3_i          (raddr3_i),
        .rdata0_o          (rdata0_o),
        .rdata1_o          (rdata1_o),
        .rdata2_o          (rdata2_o),
        .rdata3_o          (rdata3_o),
        .hi_o              (hi_o),
        .lo_o              (lo_o),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .trace_afull_o     (trace_afull_o),
        .trace_ovf_o       (trace_ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        wen0_i = 1'b0; waddr0_i = '0; ls0_i = '0; memout0_i = '0; aluout0_i = '0; pc0_i = '0;
        wen1_i = 1'b0; waddr1_i = '0; aluout1_i = '0; pc1_i = '0;
        hilo_we_i = '0; hilo_wdata_i = '0;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [4:0] wnum,
                            input logic [31:0] wdata, input logic [3:0] wen);
        tr_t e;
        e.pc = pc; e.wnum = wnum; e.wdata = wdata; e.wen = wen;
        sb.push_back(e);
    endtask

    // Monitor: a trace output is a non-zero wen or a new PC (all test PCs are unique)
    initial begin
        logic [31:0] last_pc;
        tr_t e;
        last_pc = '0;
        forever begin
            @(negedge clk or negedge resetn);
            if (!resetn) begin
                last_pc = '0;
            end else if (debug_wb_rf_wen != 4'h0 || debug_wb_pc != last_pc) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL trace_unexpected: got pc %h wnum %0d, required no entry",
                             debug_wb_pc, debug_wb_rf_wnum);
                end else begin
                    e = sb.pop_front();
                    check("trace_pc",    debug_wb_pc,       e.pc);
                    check("trace_wnum",  debug_wb_rf_wnum,  e.wnum);
                    check("trace_wdata", debug_wb_rf_wdata, e.wdata);
                    check("trace_wen",   debug_wb_rf_wen,   e.wen);
                end
                last_pc = debug_wb_pc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc;
        clr();
        raddr0_i = '0; raddr1_i = '0; raddr2_i = '0; raddr3_i = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #20;

        // Reset state
        for (int r = 1; r < 32; r++) begin
            raddr0_i = 5'(r);
            #1 check("reset_gpr", rdata0_o, 32'h0);
        end
        check("reset_hi", hi_o, 32'h0);
        check("reset_lo", lo_o, 32'h0);
        check("reset_wen", debug_wb_rf_wen, 4'h0);
        check("reset_ovf", trace_ovf_o, 1'b0);
        check("reset_afull", trace_afull_o, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // Load writeback selects memout and bypasses same cycle
        @(negedge clk);
        wen0_i = 1'b1; waddr0_i = 5'd5; ls0_i = 2'b01;
        memout0_i = 32'hDEAD_BEEF; aluout0_i = 32'h1; pc0_i = 32'h100;
        raddr0_i = 5'd5;
        push_exp(32'h100, 5'd5, 32'hDEAD_BEEF, 4'hf);
        #1 check("bypass_load", rdata0_o, 32'hDEAD_BEEF);
        @(posedge clk); @(negedge clk);
        clr();
        #1 check("stored_load", rdata0_o, 32'hDEAD_BEEF);

        // Non-load class selects aluout
        wen0_i = 1'b1; waddr0_i = 5'd6; ls0_i = 2'b10;
        memout0_i = 32'hFFFF_FFFF; aluout0_i = 32'h1234; pc0_i = 32'h180;
        raddr1_i = 5'd6;
        push_exp(32'h180, 5'd6, 32'h1234, 4'hf);
        #1 check("bypass_alu", rdata1_o, 32'h1234);
        @(posedge clk); @(negedge clk);
        clr();
        #1 check("stored_alu", rdata1_o, 32'h1234);
        check("keep_r5", rdata0_o, 32'hDEAD_BEEF);
        repeat (4) @(negedge clk);

        // Dual commit to the same register: slot 1 wins; trace in program order
        wen0_i = 1'b1; waddr0_i = 5'd7; ls0_i = 2'b00; aluout0_i = 32'h11; pc0_i = 32'h200;
        wen1_i = 1'b1; waddr1_i = 5'd7; aluout1_i = 32'h22; pc1_i = 32'h204;
        raddr2_i = 5'd7; raddr3_i = 5'd5;
        push_exp(32'h200, 5'd7, 32'h11, 4'hf);
        push_exp(32'h204, 5'd7, 32'h22, 4'hf);
        #1 check("bypass_dual", rdata2_o, 32'h22);
        check("read_r5_slot1port", rdata3_o, 32'hDEAD_BEEF);
        @(posedge clk); @(negedge clk);
        clr();
        #1 check("stored_dual", rdata2_o, 32'h22);
        check("trace_not_early", debug_wb_rf_wen, 4'h0);
        @(negedge clk);
        #1 check("lat_slot0_data", debug_wb_rf_wdata, 32'h11);
        check("lat_slot0_pc", debug_wb_pc, 32'h200);
        @(negedge clk);
        #1 check("lat_slot1_data", debug_wb_rf_wdata, 32'h22);
        check("lat_slot1_pc", debug_wb_pc, 32'h204);

        // Write to r0: not stored, traced with wen 0
        wen0_i = 1'b1; waddr0_i = 5'd0; aluout0_i = 32'h55; pc0_i = 32'h300;
        raddr0_i = 5'd0;
        push_exp(32'h300, 5'd0, 32'h55, 4'h0);
        #1 check("r0_bypass", rdata0_o, 32'h0);
        @(posedge clk); @(negedge clk);
        clr();
        #1 check("r0_stored", rdata0_o, 32'h0);
        repeat (3) @(negedge clk);

        // HI/LO independent enables with bypass
        hilo_we_i = 2'b10; hilo_wdata_i = 64'hAAAA_AAAA_BBBB_BBBB;
        #1 check("hi_bypass", hi_o, 32'hAAAA_AAAA);
        check("lo_unbypassed", lo_o, 32'h0);
        @(posedge clk); @(negedge clk);
        clr();
        #1 check("hi_stored", hi_o, 32'hAAAA_AAAA);
        check("lo_unchanged", lo_o, 32'h0);
        hilo_we_i = 2'b01; hilo_wdata_i = 64'h1111_1111_2222_2222;
        #1 check("lo_bypass", lo_o, 32'h2222_2222);
        check("hi_held", hi_o, 32'hAAAA_AAAA);
        @(posedge clk); @(negedge clk);
        clr();
        #1 check("lo_stored", lo_o, 32'h2222_2222);
        check("hi_still", hi_o, 32'hAAAA_AAAA);
        repeat (2) @(negedge clk);

        // Back-to-back dual commits from empty: occupancy 2,3,4 then a drop
        for (int k = 0; k < 4; k++) begin
            pc = 32'h400 + 32'(k * 16);
            wen0_i = 1'b1; waddr0_i = 5'(10 + 2 * k); ls0_i = 2'b00;
            aluout0_i = 32'h1000 + 32'(k); pc0_i = pc;
            wen1_i = 1'b1; waddr1_i = 5'(11 + 2 * k);
            aluout1_i = 32'h2000 + 32'(k); pc1_i = pc + 32'h4;
            push_exp(pc, 5'(10 + 2 * k), 32'h1000 + 32'(k), 4'hf);
            if (k < 3) push_exp(pc + 32'h4, 5'(11 + 2 * k), 32'h2000 + 32'(k), 4'hf);
            @(posedge clk); @(negedge clk);
            #1 check("afull_step", trace_afull_o, (k >= 1) ? 1'b1 : 1'b0);
            check("ovf_step", trace_ovf_o, (k == 3) ? 1'b1 : 1'b0);
        end
        clr();
        raddr0_i = 5'd17;
        #1 check("gpr_not_blocked", rdata0_o, 32'h2003);
        @(negedge clk);
        #1 check("ovf_sticky1", trace_ovf_o, 1'b1);
        @(negedge clk);
        #1 check("ovf_sticky2", trace_ovf_o, 1'b1);

        // Asynchronous reset pulse mid-drain
        resetn = 1'b0;
        sb.delete();
        #1 check("rst_wen", debug_wb_rf_wen, 4'h0);
        check("rst_afull", trace_afull_o, 1'b0);
        check("rst_ovf", trace_ovf_o, 1'b0);
        check("rst_gpr", rdata0_o, 32'h0);
        check("rst_hi", hi_o, 32'h0);
        #1 resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check("post_rst_wen", debug_wb_rf_wen, 4'h0);
            check("post_rst_afull", trace_afull_o, 1'b0);
        end

        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
